// File: rtl/hammer_sprite_loader.sv
// Hammer sprite loader: unpacks a byte stream of palette codes into sprite RAM pixel writes.
// Optional build macro HAMMER_LDR_CHROMA_SKIP_EN suppresses writes of chroma-key code 0.
module hammer_sprite_loader #(
    parameter int unsigned ADDR = 10,
    parameter int unsigned PW   = 4,
    parameter int unsigned BW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR-1:0] base_addr,
    input  logic [ADDR:0]   len,
    input  logic            abort,
    input  logic [BW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [PW-1:0]   pixel_in,
    output logic            busy,
    output logic            done
);

`ifdef HAMMER_LDR_CHROMA_SKIP_EN
    localparam bit ChromaSkip = 1'b1;
`else
    localparam bit ChromaSkip = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StFetch, StWrLo, StWrHi, StFin} state_e;

    state_e          state_q, state_d;
    logic [ADDR-1:0] ptr_q, ptr_d;
    logic [ADDR:0]   rem_q, rem_d;
    logic [PW-1:0]   hi_q, hi_d;
    logic            we_q, we_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [PW-1:0]   pix_q, pix_d;

    logic            wr_go;
    logic [ADDR-1:0] wr_addr;
    logic [PW-1:0]   wr_pix;
    logic            last_pix;

    assign last_pix = (rem_q == (ADDR+1)'(1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        pix_d   = pix_q;
        wr_go   = 1'b0;
        wr_addr = ptr_q;
        wr_pix  = s_data[PW-1:0];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != '0) begin
                        ptr_d   = base_addr;
                        rem_d   = len;
                        state_d = StFetch;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StFetch: begin
                if (s_valid) begin
                    hi_d    = s_data[BW-1:PW];
                    wr_go   = 1'b1;
                    state_d = StWrLo;
                end
            end
            StWrLo: begin
                ptr_d = ptr_q + 1'b1;
                rem_d = rem_q - 1'b1;
                if (last_pix) begin
                    state_d = StFin;
                end else begin
                    wr_go   = 1'b1;
                    wr_addr = ptr_q + 1'b1;
                    wr_pix  = hi_q;
                    state_d = StWrHi;
                end
            end
            StWrHi: begin
                ptr_d   = ptr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = last_pix ? StFin : StFetch;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // The write on the bus during an abort cycle lands; nothing after it is issued.
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            wr_go   = 1'b0;
        end

        // Write port is registered one stage ahead so it appears in WR_LO/WR_HI.
        if (wr_go && (!ChromaSkip || wr_pix != '0)) begin
            we_d   = 1'b1;
            addr_d = wr_addr;
            pix_d  = wr_pix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
        end
    end

    assign s_ready  = (state_q == StFetch);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign we       = we_q;
    assign addr_w   = addr_q;
    assign pixel_in = pix_q;

endmodule

// File: doc/hammer_sprite_loader.md
Name: hammer_sprite_loader

Overview:
Writer side of the hammer sprite RAM write port (we / addr_w / pixel_in). Accepts a packed byte stream of 4-bit palette codes over a valid/ready handshake. Unpacks each byte into two pixel writes at consecutive RAM addresses starting from a programmed base. Sits between the bus/UART receive path and the sprite generator, so sprite frames can be reloaded at run time.

Parameters:
ADDR, 10, sprite RAM address width; matches the sprite generator ADDR.
PW, 4, pixel (palette code) width.
BW, 8, stream byte width; must equal 2*PW.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  1-cycle load request; sampled only in IDLE
base_addr  in  ADDR  first RAM address of the load
len  in  ADDR+1  number of pixels to write, 0..2^ADDR
abort  in  1  terminates the load immediately
s_data  in  BW  packed pixels: [PW-1:0] first, [BW-1:PW] second
s_valid  in  1  s_data valid
s_ready  out  1  loader accepts a byte this cycle
we  out  1  sprite RAM write enable
addr_w  out  ADDR  sprite RAM write address
pixel_in  out  PW  sprite RAM write data
busy  out  1  load in progress
done  out  1  1-cycle pulse when a load completes normally

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: state=IDLE; we=0, addr_w=0, pixel_in=0, s_ready=0, busy=0, done=0. Internal pointer and remaining-count registers clear to 0.
- Registered outputs: all outputs are registers or decoded from the state register only. There is no combinational path from any input to any output.
- FSM states: IDLE, FETCH, WR_LO, WR_HI, FIN.
- IDLE:
  - On start with len!=0: load ptr=base_addr and rem=len, then go to FETCH.
  - On start with len==0: go straight to FIN.
  - start in any other state is ignored.
- FETCH:
  - s_ready=1.
  - On s_valid&&s_ready: latch s_data and go to WR_LO.
  - Without s_valid: stay in FETCH. No timeout.
- WR_LO (one cycle): we=1, addr_w=ptr, pixel_in=byte[PW-1:0]; ptr+=1, rem-=1.
  - If rem was 1, go to FIN.
  - Otherwise go to WR_HI.
- WR_HI (one cycle): we=1, addr_w=ptr, pixel_in=byte[BW-1:PW]; ptr+=1, rem-=1.
  - If rem was 1, go to FIN.
  - Otherwise go to FETCH.
- Odd len: the high nibble of the final byte is consumed and discarded.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- Throughput: one byte per 3 cycles (FETCH, WR_LO, WR_HI). The first write occurs 1 cycle after the accepting handshake.
- Address arithmetic: ptr is ADDR bits and wraps modulo 2^ADDR (0x3FF -> 0x000). len=2^ADDR writes the whole RAM exactly once.
- abort:
  - Has priority over every transition. From any non-IDLE state, go to IDLE on the next edge with we=0 and no done pulse.
  - A write already presented in the abort cycle still completes.
  - In IDLE, abort is ignored.
- start and abort together in IDLE: abort is ignored; start is honoured.
- Async reset mid-load: state returns to IDLE and we deasserts immediately. RAM contents written so far are retained.
- we is 0 in IDLE, FETCH and FIN.
- addr_w and pixel_in hold their last value when we=0.

Optional Feature:
Macro HAMMER_LDR_CHROMA_SKIP_EN.
- Defined: a pixel whose code is 0 (the chroma key) is not written. In WR_LO/WR_HI, we=0 for that pixel, but ptr and rem still advance and timing is unchanged. This lets a transparent overlay be loaded without erasing pixels already in the RAM.
- Undefined: every pixel is written, including code 0.

Test Plan:
1. Reset, then start with base=0x000, len=4 and bytes 0x1D, 0xFE → writes (0x000,D), (0x001,1), (0x002,E), (0x003,F); done pulses once, 1 cycle after the last write; busy falls with done.
2. base=0x3FE, len=3, bytes 0x21, 0x43 → writes (0x3FE,1), (0x3FF,2), (0x000,3); nibble 4 discarded; exactly 2 handshakes.
3. s_valid toggled on alternate cycles → s_ready stays high in FETCH until the handshake; no write occurs while waiting; write order and data are correct.
4. len=0 → no handshake, no we; done pulses on the 2nd cycle after start.
5. abort asserted in WR_HI of the 2nd byte with len=8 → exactly 4 writes, no done; a new start loads correctly. Async reset during FETCH → outputs return to reset values without waiting for a clock edge.
6. With HAMMER_LDR_CHROMA_SKIP_EN: byte 0x0F with len=2 → one write (0x000,F); the address-0x001 cycle has we=0; done timing is identical to the build without the macro.
